// File: rtl/cp0_irq_unit.sv
// Coprocessor-0 for Minisys-1A: Status/Cause/EPC, exception and eret bookkeeping,
// synchronised edge-latched external interrupts and a registered ifetch redirect.
module cp0_irq_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_IRQ     = 6,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR  = 32'h0000F000,
  parameter logic [DATA_WIDTH-1:0] STATUS_INIT = 32'h00000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] commit_pc_plus_4,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic                  eret,
  input  logic                  mtc0_en,
  input  logic [4:0]            cp0_addr,
  input  logic [DATA_WIDTH-1:0] cp0_wdata,
  output logic [DATA_WIDTH-1:0] cp0_rdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  int_taken,
  output logic                  in_handler
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  localparam logic [DATA_WIDTH-1:0] IP_MASK =
    {{(DATA_WIDTH-8-NUM_IRQ){1'b0}}, {NUM_IRQ{1'b1}}, 8'h00};
  localparam logic [DATA_WIDTH-1:0] STATUS_MASK = IP_MASK | {{(DATA_WIDTH-2){1'b0}}, 2'b11};
  localparam logic [DATA_WIDTH-1:0] CAUSE_MASK  = IP_MASK | {{(DATA_WIDTH-7){1'b0}}, 7'h7C};

  logic [DATA_WIDTH-1:0] status_q, cause_q, epc_q;
  logic [DATA_WIDTH-1:0] cause_next, edge_word, code_word;
  logic [NUM_IRQ-1:0]    sync1, sync2, prev;
  logic                  ie, exl, int_req;
  logic                  take_exc, take_int, take_eret, take_mtc0;

  assign ie         = status_q[0];
  assign exl        = status_q[1];
  assign in_handler = exl;

  // IM and IP share bit positions, so the pending-and-enabled test is a plain AND.
  assign int_req   = commit & ie & ~exl & (|(cause_q & status_q & IP_MASK));
  assign take_exc  = exc_valid;
  assign take_int  = ~exc_valid & int_req;
  assign take_eret = ~exc_valid & ~int_req & eret;
  assign take_mtc0 = mtc0_en & ~(exc_valid | int_req | eret);

  always_comb begin
    edge_word = '0;
    edge_word[8 +: NUM_IRQ] = sync2 & ~prev;
    code_word = '0;
    code_word[6:2] = exc_code;
  end

  // Newly latched edges are ORed in last so they survive a software clear.
  always_comb begin
    cause_next = cause_q | edge_word;
    if (take_exc || take_int) begin
      cause_next = (cause_q & IP_MASK) | edge_word | (take_exc ? code_word : '0);
    end else if (take_mtc0 && cp0_addr == ADDR_CAUSE) begin
      cause_next = (cp0_wdata & CAUSE_MASK) | edge_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      status_q       <= STATUS_INIT & STATUS_MASK;
      cause_q        <= '0;
      epc_q          <= '0;
      sync1          <= '0;
      sync2          <= '0;
      prev           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      int_taken      <= 1'b0;
    end else begin
      sync1          <= irq_in;
      sync2          <= sync1;
      prev           <= sync2;
      cause_q        <= cause_next;
      redirect_valid <= take_exc | take_int | take_eret;
      int_taken      <= take_int;
      if (take_exc || take_int) begin
        status_q[1] <= 1'b1;
        if (!exl) epc_q <= commit_pc_plus_4;
        redirect_pc <= EXC_VECTOR;
      end else if (take_eret) begin
        status_q[1] <= 1'b0;
        redirect_pc <= epc_q;
      end else if (take_mtc0) begin
        if (cp0_addr == ADDR_STATUS) status_q <= cp0_wdata & STATUS_MASK;
        else if (cp0_addr == ADDR_EPC) epc_q <= cp0_wdata;
      end
    end
  end

  always_comb begin
    case (cp0_addr)
      ADDR_STATUS: cp0_rdata = status_q;
      ADDR_CAUSE:  cp0_rdata = cause_q;
      ADDR_EPC:    cp0_rdata = epc_q;
      default:     cp0_rdata = '1;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_unit.sv
// Directed and randomized checks of cp0_irq_unit against a field-level behavioural model.
module tb_cp0_irq_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        commit;
  logic [31:0] commit_pc_plus_4;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret;
  logic        mtc0_en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        int_taken;
  logic        in_handler;

  cp0_irq_unit #(
    .DATA_WIDTH (32),
    .NUM_IRQ    (6),
    .EXC_VECTOR (32'h0000F000),
    .STATUS_INIT(32'h0000FF01)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .irq_in          (irq_in),
    .commit          (commit),
    .commit_pc_plus_4(commit_pc_plus_4),
    .exc_valid       (exc_valid),
    .exc_code        (exc_code),
    .eret            (eret),
    .mtc0_en         (mtc0_en),
    .cp0_addr        (cp0_addr),
    .cp0_wdata       (cp0_wdata),
    .cp0_rdata       (cp0_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .int_taken       (int_taken),
    .in_handler      (in_handler)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: architectural fields plus a history of sampled irq lines.
  logic        m_ie, m_exl, m_rv, m_it;
  logic [5:0]  m_im, m_ip;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_rpc;
  logic [5:0]  hist [1:3];

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return {16'h0, 2'b00, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {16'h0, 2'b00, m_ip, 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  task automatic model_step();
    logic [5:0] rise;
    logic       req;
    if (reset) begin
      m_ie = 1'b1; m_exl = 1'b0; m_im = 6'h3F;
      m_ip = '0; m_code = '0; m_epc = '0;
      m_rv = 1'b0; m_it = 1'b0; m_rpc = '0;
      for (int k = 1; k <= 3; k++) hist[k] = '0;
    end else begin
      // A line high for the first time two samples ago counts as a new request now.
      rise = hist[2] & ~hist[3];
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = irq_in;
      req = commit && m_ie && !m_exl && ((m_ip & m_im) != 0);
      if (exc_valid || req) begin
        if (!m_exl) m_epc = commit_pc_plus_4;
        m_code = exc_valid ? exc_code : 5'd0;
        m_exl = 1'b1; m_rv = 1'b1; m_rpc = 32'h0000F000; m_it = !exc_valid;
      end else if (eret) begin
        m_rv = 1'b1; m_rpc = m_epc; m_exl = 1'b0; m_it = 1'b0;
      end else begin
        m_rv = 1'b0; m_it = 1'b0;
        if (mtc0_en) begin
          case (cp0_addr)
            5'd12: begin m_ie = cp0_wdata[0]; m_exl = cp0_wdata[1]; m_im = cp0_wdata[13:8]; end
            5'd13: begin m_code = cp0_wdata[6:2]; m_ip = cp0_wdata[13:8]; end
            5'd14: m_epc = cp0_wdata;
            default: ;
          endcase
        end
      end
      m_ip = m_ip | rise;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
    check("redirect_pc", redirect_pc, m_rpc);
    check("int_taken", {31'b0, int_taken}, {31'b0, m_it});
    check("in_handler", {31'b0, in_handler}, {31'b0, m_exl});
    check("cp0_rdata", cp0_rdata, m_read(cp0_addr));
  endtask

  task automatic peek(input logic [4:0] a, input string tag);
    cp0_addr = a;
    #1;
    check(tag, cp0_rdata, m_read(a));
  endtask

  task automatic idle();
    exc_valid = 1'b0; eret = 1'b0; mtc0_en = 1'b0;
  endtask

  task automatic write_cp0(input logic [4:0] a, input logic [31:0] d);
    mtc0_en = 1'b1; cp0_addr = a; cp0_wdata = d;
    tick();
    mtc0_en = 1'b0;
  endtask

  int lat;

  initial begin
    reset = 1'b1; irq_in = '0; commit = 1'b0; commit_pc_plus_4 = '0;
    exc_code = '0; cp0_addr = 5'd12; cp0_wdata = '0;
    idle();
    tick(); tick();
    reset = 1'b0;
    peek(5'd12, "reset_status"); check("reset_status_const", cp0_rdata, 32'h00003F01);
    peek(5'd13, "reset_cause");
    peek(5'd14, "reset_epc");
    peek(5'd5, "miss_read");     check("miss_read_const", cp0_rdata, 32'hFFFFFFFF);

    // syscall
    commit = 1'b1; exc_valid = 1'b1; exc_code = 5'd8; commit_pc_plus_4 = 32'h104;
    tick(); idle();
    check("sys_rpc_const", redirect_pc, 32'h0000F000);
    peek(5'd14, "sys_epc");      check("sys_epc_const", cp0_rdata, 32'h104);
    peek(5'd13, "sys_cause");
    tick();

    // nested break keeps EPC; pending irq not taken while EXL=1
    exc_valid = 1'b1; exc_code = 5'd9; commit_pc_plus_4 = 32'h200;
    tick(); idle();
    peek(5'd14, "nest_epc");     check("nest_epc_const", cp0_rdata, 32'h104);
    peek(5'd13, "nest_cause");
    irq_in[0] = 1'b1;
    repeat (6) tick();
    check("nest_no_int", {31'b0, in_handler}, 32'd1);
    irq_in = '0;

    // eret, then clear pending
    commit = 1'b0; eret = 1'b1;
    tick(); idle();
    check("eret_rpc_const", redirect_pc, 32'h104);
    write_cp0(5'd13, 32'h0);

    // eret together with exception: exception wins
    exc_valid = 1'b1; eret = 1'b1; exc_code = 5'd12; commit_pc_plus_4 = 32'h300;
    tick(); idle();
    check("exc_beats_eret", {31'b0, in_handler}, 32'd1);
    eret = 1'b1; tick(); idle();

    // interrupt on line 2 with IM[10]=1
    write_cp0(5'd12, 32'h401);
    commit = 1'b1; irq_in = 6'b000100;
    tick(); irq_in = '0;
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (int_taken && lat < 0) lat = k;
    end
    check("int_latency", lat, 32'd2);
    peek(5'd13, "int_cause");
    commit = 1'b0; eret = 1'b1; tick(); idle();
    write_cp0(5'd13, 32'h0);

    // same stimulus masked: stays pending
    write_cp0(5'd12, 32'h001);
    commit = 1'b1; irq_in = 6'b000100;
    tick(); irq_in = '0;
    repeat (6) tick();
    peek(5'd13, "masked_cause"); check("masked_cause_const", cp0_rdata, 32'h400);

    // ack race on IP[8]
    commit = 1'b0;
    write_cp0(5'd13, 32'h0);
    irq_in[0] = 1'b1;
    tick(); tick();
    write_cp0(5'd13, 32'h0);
    peek(5'd13, "race_cause");   check("race_cause_const", cp0_rdata, 32'h100);
    write_cp0(5'd13, 32'h0);
    peek(5'd13, "ack_cause");    check("ack_cause_const", cp0_rdata, 32'h0);
    irq_in = '0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) irq_in = 6'($urandom);
      commit = 1'($urandom);
      exc_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: exc_code = 5'd8;
        1: exc_code = 5'd9;
        2: exc_code = 5'd10;
        default: exc_code = 5'd12;
      endcase
      eret = ($urandom_range(0, 11) == 0);
      mtc0_en = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0: cp0_addr = 5'd12;
        1: cp0_addr = 5'd13;
        2: cp0_addr = 5'd14;
        default: cp0_addr = 5'($urandom);
      endcase
      cp0_wdata = $urandom;
      commit_pc_plus_4 = $urandom & 32'hFFFFFFFC;
      tick();
    end
    reset = 1'b0; idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cp0_irq_unit.md
Name: cp0_irq_unit

Overview:
Parametrised coprocessor-0 block for the Minisys-1A CPU. It holds Status (reg 12), Cause (reg 13) and EPC (reg 14), and takes over all exception and eret bookkeeping from the decode stage. It adds NUM_IRQ external interrupt lines with synchronisers, edge-latched pending bits, per-line masking, and an EXL nesting guard. Control-flow changes leave as a registered one-cycle redirect pulse to ifetch.

Parameters:
DATA_WIDTH, 32, width of CP0 registers and PCs.
NUM_IRQ, 6, number of external interrupt lines; legal range 1..8.
EXC_VECTOR, 32'h0000F000, handler entry address.
STATUS_INIT, 32'h00000000, Status value loaded on reset.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
irq_in  in  NUM_IRQ  asynchronous interrupt request lines, level-high
commit  in  1  an instruction retires this cycle; interrupts are taken only when this is 1
commit_pc_plus_4  in  DATA_WIDTH  PC+4 of the retiring instruction
exc_valid  in  1  synchronous exception raised by the retiring instruction
exc_code  in  5  ExcCode: 8 syscall, 9 break, 10 reserved instruction, 12 overflow
eret  in  1  eret retiring
mtc0_en  in  1  mtc0 retiring
cp0_addr  in  5  rd field for mtc0/mfc0
cp0_wdata  in  DATA_WIDTH  rt value for mtc0
cp0_rdata  out  DATA_WIDTH  combinational mfc0 read data
redirect_valid  out  1  one-cycle pulse: ifetch must load redirect_pc
redirect_pc  out  DATA_WIDTH  redirect target
int_taken  out  1  one-cycle pulse coincident with redirect_valid when the cause is an interrupt
in_handler  out  1  Status.EXL

Behaviour:
Register layout
- Status: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM; other bits read 0 and are write-ignored.
- Cause: bits[6:2] ExcCode, bits[8+NUM_IRQ-1:8] IP; other bits read 0.
- EPC: full width.

Reset
- Status = STATUS_INIT masked to the legal bits; Cause = 0; EPC = 0.
- Synchroniser flops cleared.
- redirect_valid = 0, redirect_pc = 0, int_taken = 0.
- Reset beats every other input in the same cycle.

Interrupt path
- Each irq_in passes through a 2-flop synchroniser plus a previous-value flop.
- A synchronised rising edge sets IP[i]. IP[i] stays set until mtc0 to Cause writes 0 to that bit.
- Latency: a rising edge at cycle n is visible in IP at cycle n+3.
- int_req = IE & ~EXL & |(IP & IM) & commit.

Priority per cycle (highest first): exc_valid, then int_req, then eret, then mtc0_en.
- Exception or interrupt:
  - If EXL=0: EPC <= commit_pc_plus_4.
  - If EXL=1: EPC is unchanged (a nested exception keeps the original EPC).
  - ExcCode <= exc_code for an exception, 0 for an interrupt.
  - EXL <= 1.
  - Next cycle: redirect_valid = 1, redirect_pc = EXC_VECTOR. int_taken = 1 only for an interrupt.
- eret:
  - EXL <= 0.
  - Next cycle: redirect_valid = 1, redirect_pc = EPC value before the edge.
  - With EXL already 0, the redirect still fires and EXL stays 0.
- mtc0:
  - Writes the addressed register at the edge; other addresses are ignored.
  - A write to Cause updates only ExcCode and IP. An IP bit being set by an edge in the same cycle wins over a software 0.
  - New Status takes effect for int_req from the next cycle.
  - An mtc0 in the same cycle as a taken exception, interrupt or eret is dropped.
- redirect_valid is never high two consecutive cycles unless two qualifying events retire back-to-back.

mfc0 read
- cp0_rdata is combinational on cp0_addr and shows current register contents (pre-edge).
- Addresses other than 12, 13 and 14 return all ones, per the CPU's CP0-miss convention.

Test Plan:
- Reset: assert reset 2 cycles with STATUS_INIT=32'h0000FF01 -> Status reads 32'h00003F01 (NUM_IRQ=6), Cause and EPC read 0, redirect_valid=0; mfc0 addr 5 returns 32'hFFFFFFFF.
- Syscall: exc_valid=1, exc_code=8, commit_pc_plus_4=32'h00000104 -> next cycle redirect_valid=1, redirect_pc=32'h0000F000; EPC=32'h104, Cause[6:2]=8, EXL=1, int_taken=0.
- Interrupt: Status=32'h00000401, pulse irq_in[2] high, hold commit=1 -> IP[10] set 3 cycles later, interrupt taken that cycle, then int_taken=1 and redirect to 32'hF000, ExcCode=0; same stimulus with IM[10]=0 -> no redirect, IP[10] stays 1.
- Nesting: with EXL=1, break at commit_pc_plus_4=32'h200 -> EPC unchanged, ExcCode=9, redirect to 32'hF000; pending IRQ is not taken while EXL=1.
- eret: EPC=32'h104 -> next cycle redirect_pc=32'h104, EXL=0; an eret and an exception in the same cycle -> exception wins and EXL stays 1.
- Ack race: mtc0 Cause clearing IP[8] in the cycle a new irq_in[0] edge arrives -> IP[8] remains 1; mtc0 alone clears it.
